// File: rtl/riscv_alu_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_alu_arbiter
//   Shares one riscv_alu between N_REQ requesters. Round-robin arbitration,
//   at most one ALU operation per cycle, results registered per requester and
//   returned one cycle after acceptance through a valid/ready response slot.
//
//   Contents: riscv_alu_pkg (opcode encoding), riscv_alu (combinational ALU),
//   riscv_alu_arbiter (top).
//
//   Top ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     req_valid_i       per-requester request valid
//     req_ready_o       request accepted this cycle (one-hot or zero)
//     req_opcode_i      packed per-requester opcode
//     req_op_a/b_i      packed per-requester result operands
//     req_cmp_a/b_i     packed per-requester compare operands
//     rsp_valid_o       per-requester response valid
//     rsp_ready_i       per-requester response consumed
//     rsp_res_o/add_o   registered ALU res_o / add_o
//     rsp_flag_o        registered ALU flag_o
// ---------------------------------------------------------------------------

package riscv_alu_pkg;
   localparam int ALU_OP_WIDTH = 4;

   // {alt, funct3}; alt selects subtract / arithmetic shift
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'b0001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 4'b0010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'b0011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'b0100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'b0101;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'b0110;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'b0111;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'b1000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'b1010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'b1011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'b1101;

   // Branch compares share the set-less-than encodings
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = ALU_SLTS;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = ALU_SLTU;
endpackage

// ---------------------------------------------------------------------------
// riscv_alu: purely combinational.
//   res_o  : result of opcode applied to op_a/op_b
//   add_o  : adder output op_a +/- op_b (subtract when opcode MSB set)
//   flag_o : compare of cmp_a/cmp_b; only meaningful for compare opcodes
// ---------------------------------------------------------------------------
module riscv_alu #(
   parameter int XLEN         = 32,
   parameter int ALU_OP_WIDTH = riscv_alu_pkg::ALU_OP_WIDTH
) (
   input  logic [ALU_OP_WIDTH-1:0] opcode_i,
   input  logic [XLEN-1:0]         op_a_i,
   input  logic [XLEN-1:0]         op_b_i,
   input  logic [XLEN-1:0]         cmp_a_i,
   input  logic [XLEN-1:0]         cmp_b_i,
   output logic [XLEN-1:0]         res_o,
   output logic [XLEN-1:0]         add_o,
   output logic                    flag_o
);
   import riscv_alu_pkg::*;

   localparam int SHW = $clog2(XLEN);

   logic            alt;
   logic [XLEN-1:0] b_op;
   logic [SHW-1:0]  shamt;

   assign alt   = opcode_i[ALU_OP_WIDTH-1];
   assign b_op  = alt ? ~op_b_i : op_b_i;
   assign shamt = op_b_i[SHW-1:0];

   // Two's complement subtract: a + ~b + 1
   assign add_o = op_a_i + b_op + {{(XLEN-1){1'b0}}, alt};

   always_comb begin
      res_o = '0;
      case (opcode_i[2:0])
         3'b000: res_o = add_o;
         3'b001: res_o = op_a_i << shamt;
         3'b010: res_o = alt ? '0 : {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
         3'b011: res_o = alt ? '0 : {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
         3'b100: res_o = op_a_i ^ op_b_i;
         3'b101: res_o = alt ? XLEN'($signed(op_a_i) >>> shamt) : op_a_i >> shamt;
         3'b110: res_o = op_a_i | op_b_i;
         3'b111: res_o = op_a_i & op_b_i;
         default: res_o = '0;
      endcase
   end

   always_comb begin
      flag_o = 1'b0;
      case (opcode_i)
         ALU_SLTS: flag_o = $signed(cmp_a_i) < $signed(cmp_b_i);
         ALU_SLTU: flag_o = cmp_a_i < cmp_b_i;
         ALU_EQ:   flag_o = cmp_a_i == cmp_b_i;
         ALU_NE:   flag_o = cmp_a_i != cmp_b_i;
         default:  flag_o = 1'b0;
      endcase
   end
endmodule

// ---------------------------------------------------------------------------
// riscv_alu_arbiter: top
// ---------------------------------------------------------------------------
module riscv_alu_arbiter #(
   parameter int XLEN         = 32,
   parameter int N_REQ        = 2,
   parameter int ALU_OP_WIDTH = riscv_alu_pkg::ALU_OP_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   output logic [N_REQ-1:0]              req_ready_o,
   input  logic [N_REQ*ALU_OP_WIDTH-1:0] req_opcode_i,
   input  logic [N_REQ*XLEN-1:0]         req_op_a_i,
   input  logic [N_REQ*XLEN-1:0]         req_op_b_i,
   input  logic [N_REQ*XLEN-1:0]         req_cmp_a_i,
   input  logic [N_REQ*XLEN-1:0]         req_cmp_b_i,
   output logic [N_REQ-1:0]              rsp_valid_o,
   input  logic [N_REQ-1:0]              rsp_ready_i,
   output logic [N_REQ*XLEN-1:0]         rsp_res_o,
   output logic [N_REQ*XLEN-1:0]         rsp_add_o,
   output logic [N_REQ-1:0]              rsp_flag_o
);
   localparam int              PW     = $clog2(N_REQ);
   localparam logic [PW:0]     NREQ_W = (PW+1)'(N_REQ);
   localparam logic [PW-1:0]   LAST   = PW'(N_REQ-1);

   logic [PW-1:0]                  prio_q, prio_d, prio_eff;
   logic [N_REQ-1:0]               elig, grant;
   logic [PW-1:0]                  gnt_idx;
   logic                           gnt_any;
   logic [PW:0]                    scan;

   logic [N_REQ-1:0]               rsp_valid_q, rsp_valid_d;
   logic [N_REQ-1:0]               rsp_flag_q,  rsp_flag_d;
   logic [N_REQ-1:0][XLEN-1:0]     rsp_res_q,   rsp_res_d;
   logic [N_REQ-1:0][XLEN-1:0]     rsp_add_q,   rsp_add_d;

   logic [ALU_OP_WIDTH-1:0]        alu_opcode;
   logic [XLEN-1:0]                alu_op_a, alu_op_b, alu_cmp_a, alu_cmp_b;
   logic [XLEN-1:0]                alu_res, alu_add;
   logic                           alu_flag;

   // A full response slot may only accept new work if it drains this cycle
   assign elig = req_valid_i & (~rsp_valid_q | rsp_ready_i);

   // Non-power-of-2 N_REQ leaves unused pointer codes; treat them as 0
   assign prio_eff = ({1'b0, prio_q} < NREQ_W) ? prio_q : '0;

   // Round-robin scan starting at prio_eff, wrapping mod N_REQ
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      scan    = '0;
      if (!rst_i) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, prio_eff} + (PW+1)'(k);
            if (scan >= NREQ_W) scan = scan - NREQ_W;
            if (!gnt_any && elig[scan[PW-1:0]]) begin
               grant[scan[PW-1:0]] = 1'b1;
               gnt_idx             = scan[PW-1:0];
               gnt_any             = 1'b1;
            end
         end
      end
   end

   assign req_ready_o = grant;

   always_comb begin
      if (gnt_any) prio_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      else         prio_d = prio_eff;
   end

   // Operand mux; all-zero inputs when nothing is granted
   always_comb begin
      alu_opcode = '0;
      alu_op_a   = '0;
      alu_op_b   = '0;
      alu_cmp_a  = '0;
      alu_cmp_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            alu_opcode = req_opcode_i[i*ALU_OP_WIDTH +: ALU_OP_WIDTH];
            alu_op_a   = req_op_a_i [i*XLEN +: XLEN];
            alu_op_b   = req_op_b_i [i*XLEN +: XLEN];
            alu_cmp_a  = req_cmp_a_i[i*XLEN +: XLEN];
            alu_cmp_b  = req_cmp_b_i[i*XLEN +: XLEN];
         end
      end
   end

   riscv_alu #(
      .XLEN         (XLEN),
      .ALU_OP_WIDTH (ALU_OP_WIDTH)
   ) u_alu (
      .opcode_i (alu_opcode),
      .op_a_i   (alu_op_a),
      .op_b_i   (alu_op_b),
      .cmp_a_i  (alu_cmp_a),
      .cmp_b_i  (alu_cmp_b),
      .res_o    (alu_res),
      .add_o    (alu_add),
      .flag_o   (alu_flag)
   );

   // Grant wins over drain so a draining slot refills with no bubble
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_flag_d  = rsp_flag_q;
      rsp_res_d   = rsp_res_q;
      rsp_add_d   = rsp_add_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_res_d[i]   = alu_res;
            rsp_add_d[i]   = alu_add;
            rsp_flag_d[i]  = alu_flag;
         end else if (rsp_valid_q[i] && rsp_ready_i[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q      <= '0;
         rsp_valid_q <= '0;
         rsp_flag_q  <= '0;
         rsp_res_q   <= '0;
         rsp_add_q   <= '0;
      end else begin
         prio_q      <= prio_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_flag_q  <= rsp_flag_d;
         rsp_res_q   <= rsp_res_d;
         rsp_add_q   <= rsp_add_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_flag_o  = rsp_flag_q;
   assign rsp_res_o   = rsp_res_q;
   assign rsp_add_o   = rsp_add_q;
endmodule

// File: tb/tb_riscv_alu_arbiter.sv
module tb_riscv_alu_arbiter;
   import riscv_alu_pkg::*;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a, b, ca, cb;
      logic [31:0] res, add;
      logic        flag;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_flag;
   logic [1:0][3:0]  opc;
   logic [1:0][31:0] op_a, op_b, cmp_a, cmp_b, rsp_res, rsp_add;

   int   checks = 0;
   int   errors = 0;
   vec_t stim_q[2][$];
   vec_t exp_q[2][$];
   vec_t mon_e;

   always #5 clk = ~clk;

   riscv_alu_arbiter #(.XLEN(32), .N_REQ(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_opcode_i (opc),
      .req_op_a_i   (op_a),
      .req_op_b_i   (op_b),
      .req_cmp_a_i  (cmp_a),
      .req_cmp_b_i  (cmp_b),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_res_o    (rsp_res),
      .rsp_add_o    (rsp_add),
      .rsp_flag_o   (rsp_flag)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, ca, cb,
                               input logic [31:0] res, add, input logic flag);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.ca = ca; v.cb = cb;
      v.res = res; v.add = add; v.flag = flag;
      return v;
   endfunction

   // Present the head of each requester's stimulus queue
   task automatic apply();
      for (int i = 0; i < 2; i++) begin
         if (stim_q[i].size() > 0) begin
            req_valid[i] = 1'b1;
            opc[i]   = stim_q[i][0].op;
            op_a[i]  = stim_q[i][0].a;
            op_b[i]  = stim_q[i][0].b;
            cmp_a[i] = stim_q[i][0].ca;
            cmp_b[i] = stim_q[i][0].cb;
         end else begin
            req_valid[i] = 1'b0;
            opc[i] = '0; op_a[i] = '0; op_b[i] = '0; cmp_a[i] = '0; cmp_b[i] = '0;
         end
      end
   endtask

   // One clock: check grant mid-cycle, hand accepted requests to the scoreboard
   task automatic cycle(input logic [1:0] exp_rdy, input string nm);
      vec_t d;
      @(negedge clk);
      chk(nm, 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < 2; i++) begin
         if (req_ready[i] && stim_q[i].size() > 0) begin
            d = stim_q[i].pop_front();
            exp_q[i].push_back(d);
         end
      end
      @(posedge clk); #1;
      apply();
   endtask

   // Monitor: compare every consumed response against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp%0d_unexpected act=%h exp=none", i, rsp_res[i]);
               end else begin
                  mon_e = exp_q[i].pop_front();
                  chk($sformatf("rsp%0d_res", i),  64'(rsp_res[i]),  64'(mon_e.res));
                  chk($sformatf("rsp%0d_add", i),  64'(rsp_add[i]),  64'(mon_e.add));
                  chk($sformatf("rsp%0d_flag", i), 64'(rsp_flag[i]), 64'(mon_e.flag));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      rsp_ready = 2'b00;
      apply();

      // Reset state, with both requesters already asking
      stim_q[0].push_back(mk(ALU_SUB,  32'd3, 32'd5, 0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0));
      stim_q[0].push_back(mk(ALU_ADD,  32'd1, 32'd1, 0, 0, 32'd2, 32'd2, 1'b0));
      stim_q[1].push_back(mk(ALU_SLTS, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 32'd0, 1'b0));
      stim_q[1].push_back(mk(ALU_XOR,  32'hF0, 32'hFF, 0, 0, 32'h0F, 32'h1EF, 1'b0));
      apply();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready",     64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_res",   rsp_res,        64'd0);
      chk("rst_rsp_add",   rsp_add,        64'd0);
      chk("rst_rsp_flag",  64'(rsp_flag),  64'd0);
      chk("rst_prio",      64'(dut.prio_q), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 2'b11;

      // Contention: strict alternation starting at req0
      cycle(2'b01, "cont_g0");
      cycle(2'b10, "cont_g1");
      cycle(2'b01, "cont_g2");
      cycle(2'b10, "cont_g3");
      cycle(2'b00, "cont_idle");

      // Single request, one-cycle latency
      stim_q[0].push_back(mk(ALU_ADD, 32'd5, 32'd7, 0, 0, 32'd12, 32'd12, 1'b0));
      apply();
      cycle(2'b01, "single_gnt");
      chk("single_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
      cycle(2'b00, "single_idle");

      // Compare flag: unsigned then signed on 0x80000000 vs 1
      stim_q[0].push_back(mk(ALU_LTU, 0, 0, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0));
      stim_q[0].push_back(mk(ALU_LTS, 0, 0, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b1));
      apply();
      cycle(2'b01, "ltu_gnt");
      cycle(2'b01, "lts_gnt");
      cycle(2'b00, "cmp_idle");

      // Backpressure on req1
      rsp_ready = 2'b01;
      stim_q[1].push_back(mk(ALU_SLL, 32'd1, 32'd4, 0, 0, 32'd16, 32'd5, 1'b0));
      apply();
      cycle(2'b10, "bp_first");
      chk("bp_res1", 64'(rsp_res[1]), 64'd16);
      stim_q[1].push_back(mk(ALU_OR,  32'd3,  32'd8, 0, 0, 32'h0B, 32'h0B, 1'b0));
      stim_q[0].push_back(mk(ALU_ADD, 32'd10, 32'd1, 0, 0, 32'd11, 32'd11, 1'b0));
      stim_q[0].push_back(mk(ALU_ADD, 32'd20, 32'd2, 0, 0, 32'd22, 32'd22, 1'b0));
      stim_q[0].push_back(mk(ALU_ADD, 32'd30, 32'd3, 0, 0, 32'd33, 32'd33, 1'b0));
      apply();
      cycle(2'b01, "bp_blocked_a");
      cycle(2'b01, "bp_blocked_b");
      rsp_ready = 2'b11;
      cycle(2'b10, "bp_drain_gnt");
      chk("bp_valid1_kept", 64'(rsp_valid[1]), 64'd1);
      chk("bp_res1_new",    64'(rsp_res[1]),   64'h0B);
      cycle(2'b01, "bp_last0");
      cycle(2'b00, "bp_idle");

      // Asynchronous reset with a pending req1 response
      rsp_ready = 2'b00;
      stim_q[1].push_back(mk(ALU_ADD, 32'd2, 32'd2, 0, 0, 32'd4, 32'd4, 1'b0));
      apply();
      cycle(2'b10, "mr_pending");
      chk("mr_valid_before", 64'(rsp_valid), 64'b10);
      stim_q[0].push_back(mk(ALU_ADD, 32'd7, 32'd0, 0, 0, 32'd7, 32'd7, 1'b0));
      stim_q[1].push_back(mk(ALU_ADD, 32'd8, 32'd0, 0, 0, 32'd8, 32'd8, 1'b0));
      apply();
      #2 rst = 1'b1;
      exp_q[0].delete();
      exp_q[1].delete();
      #1;
      chk("mr_valid_async", 64'(rsp_valid), 64'd0);
      chk("mr_ready_async", 64'(req_ready), 64'd0);
      chk("mr_res_async",   rsp_res,        64'd0);
      @(negedge clk);
      chk("mr_ready_hold",  64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 2'b11;
      cycle(2'b01, "mr_first_req0");
      cycle(2'b10, "mr_then_req1");
      stim_q[0].push_back(mk(ALU_ADD, 32'd9, 32'd9, 0, 0, 32'd18, 32'd18, 1'b0));
      apply();
      cycle(2'b01, "pre_idle_gnt");
      cycle(2'b00, "pre_idle_drain");

      // Idle: nothing moves
      for (int n = 0; n < 10; n++) cycle(2'b00, $sformatf("idle_%0d", n));
      chk("idle_prio",  64'(dut.prio_q), 64'd1);
      chk("idle_res",   rsp_res,         {32'd8, 32'd18});
      chk("idle_add",   rsp_add,         {32'd8, 32'd18});
      chk("idle_flag",  64'(rsp_flag),   64'd0);
      chk("idle_valid", 64'(rsp_valid),  64'd0);

      @(posedge clk);
      @(negedge clk); #1;
      chk("sb_empty0",   64'(exp_q[0].size()),  64'd0);
      chk("sb_empty1",   64'(exp_q[1].size()),  64'd0);
      chk("stim_empty0", 64'(stim_q[0].size()), 64'd0);
      chk("stim_empty1", 64'(stim_q[1].size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/riscv_alu_arbiter.md
Name: riscv_alu_arbiter

Overview:
Shares one riscv_alu instance between N_REQ requesters, e.g. the integer execute stage and the branch/address-generation path. Each requester gets a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin, with at most one ALU operation issued per cycle. Results are registered per requester and returned one cycle after acceptance.

Parameters:
XLEN, 32, datapath width; passed through to the ALU.
N_REQ, 2, number of requesters; legal range 2..8.
ALU_OP_WIDTH, riscv_alu_pkg::ALU_OP_WIDTH, opcode width; the MSB selects sub/arithmetic-shift.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  asynchronous, active-high reset.
req_valid_i  in  N_REQ  request valid, one bit per requester.
req_ready_o  out  N_REQ  request accepted this cycle (one-hot or zero).
req_opcode_i  in  N_REQ*ALU_OP_WIDTH  packed per-requester ALU opcode.
req_op_a_i, req_op_b_i  in  N_REQ*XLEN  packed per-requester result operands.
req_cmp_a_i, req_cmp_b_i  in  N_REQ*XLEN  packed per-requester compare operands.
rsp_valid_o  out  N_REQ  response valid per requester.
rsp_ready_i  in  N_REQ  response consumed per requester.
rsp_res_o  out  N_REQ*XLEN  registered ALU res_o.
rsp_add_o  out  N_REQ*XLEN  registered ALU add_o.
rsp_flag_o  out  N_REQ  registered ALU flag_o.

Behaviour:
- Eligibility: elig[i] = req_valid_i[i] && (!rsp_valid_o[i] || rsp_ready_i[i]). A requester whose response slot is full and not draining is never granted.
- Priority pointer prio_q (clog2(N_REQ) bits) holds the highest-priority index; reset value 0.
- grant is the first eligible index found scanning prio_q, prio_q+1, ... mod N_REQ. It is one-hot or zero.
- req_ready_o = grant, combinationally. req_ready_o may depend on req_valid_i; requesters must not wait for ready before asserting valid.
- On any grant to index g: prio_q <= (g+1) mod N_REQ. With no grant, prio_q holds.
- Requesters hold the payload stable while valid && !ready. The arbiter latches nothing until grant.
- The ALU mux selects the granted requester's opcode/op_a/op_b/cmp_a/cmp_b. With no grant, all ALU inputs are 0.
- ALU semantics are unchanged: res_o, add_o and flag_o per opcode. The flag is meaningful only for compare opcodes.
- Latency: a request accepted at edge N has rsp_valid_o high after edge N, with data stable until consumed.
- Response slot i update at the clock edge:
  - grant[i]: rsp_res/add/flag[i] <= ALU outputs; rsp_valid_o[i] <= 1. This covers a simultaneous drain and grant: valid stays high and new data replaces old with no bubble.
  - else if rsp_valid_o[i] && rsp_ready_i[i]: rsp_valid_o[i] <= 0; data holds.
  - else: hold.
- Throughput: one operation per cycle in aggregate; a single requester with rsp_ready_i held high may issue every cycle.
- Reset, asynchronous assertion: rsp_valid_o = 0, rsp_res_o = rsp_add_o = rsp_flag_o = 0, prio_q = 0. In-flight responses are discarded.
- While rst_i is high: req_ready_o = 0.
- After rst_i deasserts: the first grant goes to the lowest-index eligible requester.
- rsp_ready_i while rsp_valid_o = 0: ignored.
- Out-of-range prio_q (N_REQ not a power of 2) is unreachable; the implementation resets it to 0 if seen.

Test Plan:
- Single request: req0 ADD, op_a=5, op_b=7, rsp_ready=1. Required: req_ready_o[0]=1 same cycle; next cycle rsp_valid_o[0]=1, rsp_res=12, rsp_add=12.
- Contention: both valid for 4 cycles, rsp_ready=1. Required: grants 0,1,0,1 in that order. Req0 SUB 3-5 returns 0xFFFFFFFE. Req1 SLTS with op_a=-1, op_b=1 returns 1.
- Backpressure: req1 SLL 1<<4, rsp_ready[1]=0. Required: first accepted, rsp_res[1]=16; second req1 not granted while req0 keeps being granted; raising rsp_ready[1] grants req1 the same cycle and rsp_valid_o[1] stays high with the new data.
- Compare flag: req0 LTU, cmp_a=0x80000000, cmp_b=1 -> rsp_flag=0. Then LTS with the same operands -> rsp_flag=1.
- Reset mid-operation: pending rsp_valid_o[1]=1, assert rst_i asynchronously between edges. Required: rsp_valid_o=0 immediately and req_ready_o=0 during reset; after release with both requesting, the first grant goes to req0.
- Idle: no req_valid for 10 cycles. Required: prio_q unchanged, req_ready_o=0, response regs hold their values.
